// File: rtl/mont_reduce_sched.sv
// Round-robin scheduler serializing NUM_REQ requesters onto one Montgomery reduction unit.
// Handles modulus configuration, unit command/completion, timeout abort and a response channel.
module mont_reduce_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = 200
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_we_i,
    input  logic [WIDTH-1:0]           cfg_m_i,
    output logic                       cfg_valid_o,
    output logic                       cfg_drop_o,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       unit_start_o,
    output logic [WIDTH-1:0]           unit_x_o,
    output logic [WIDTH-1:0]           unit_m_o,
    output logic [7:0]                 unit_k_o,
    input  logic                       unit_valid_i,
    input  logic [WIDTH-1:0]           unit_result_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [WIDTH-1:0]           rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       busy_o,
    output logic [15:0]                done_cnt_o
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_m;
    logic [7:0]       r_k;
    logic             r_cfg_valid;
    logic             r_cfg_drop;
    logic             r_start;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [ID_W-1:0]  r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [15:0]      r_done_cnt;

    logic [WIDTH-1:0] w_x_arr [NUM_REQ];
    logic [7:0]       w_cfg_k;
    logic             w_cfg_ok;
    logic             w_grant_en;
    logic [ID_W-1:0]  w_grant_id;

    // Lowest rotational distance from the pointer wins among requesting slots.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_W-1:0]    p);
        logic [ID_W-1:0] best;
        int              best_d;
        int              d;
        best   = '0;
        best_d = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            d = (j >= int'(p)) ? (j - int'(p)) : (j + NUM_REQ - int'(p));
            if (v[j] && (d < best_d)) begin
                best_d = d;
                best   = ID_W'(j);
            end
        end
        return best;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi = gi + 1) begin : g_req
            assign w_x_arr[gi]     = req_x_i[gi*WIDTH +: WIDTH];
            assign req_ready_o[gi] = w_grant_en && (w_grant_id == ID_W'(gi));
        end
    endgenerate

    always_comb begin
        w_cfg_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cfg_m_i[i]) w_cfg_k = 8'(i + 1);
        end
    end

    assign w_cfg_ok   = cfg_m_i[0] && (cfg_m_i[WIDTH-1:1] != '0);
    // A config write in IDLE pre-empts the grant for that cycle.
    assign w_grant_en = (r_state == IDLE) && r_cfg_valid && !cfg_we_i && (|req_valid_i);
    assign w_grant_id = rr_pick(req_valid_i, r_ptr);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_x         <= '0;
            r_m         <= '0;
            r_k         <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_drop  <= 1'b0;
            r_start     <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_done_cnt  <= '0;
        end else begin
            r_start    <= 1'b0;
            r_cfg_drop <= 1'b0;
            if (cfg_we_i) begin
                if ((r_state == IDLE) && w_cfg_ok) begin
                    r_m         <= cfg_m_i;
                    r_k         <= w_cfg_k;
                    r_cfg_valid <= 1'b1;
                end else begin
                    r_cfg_drop <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_grant_en) begin
                        r_x     <= w_x_arr[w_grant_id];
                        r_id    <= w_grant_id;
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= CNT_W'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Completion on the timeout cycle still counts as success.
                    if (unit_valid_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= unit_result_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= r_id;
                        r_state     <= RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= '0;
                        r_ptr       <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : (r_id + ID_W'(1));
                        r_done_cnt  <= r_done_cnt + 16'd1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_valid_o  = r_cfg_valid;
    assign cfg_drop_o   = r_cfg_drop;
    assign unit_start_o = r_start;
    assign unit_x_o     = r_x;
    assign unit_m_o     = r_m;
    assign unit_k_o     = r_k;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_data_o   = r_rsp_data;
    assign rsp_err_o    = r_rsp_err;
    assign busy_o       = (r_state != IDLE);
    assign done_cnt_o   = r_done_cnt;

endmodule

// File: tb/tb_mont_reduce_sched.sv
// Directed bench for mont_reduce_sched: config vector table plus handwritten
// transaction sequences against a small latency-programmable reduction-unit model.
module tb_mont_reduce_sched;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int TO = 200;

    typedef struct {
        logic [W-1:0] m;
        logic         exp_drop;
        logic         exp_valid;
        logic [7:0]   exp_k;
        logic [W-1:0] exp_m;
    } cfg_vec_t;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           cfg_we_i;
    logic [W-1:0]   cfg_m_i;
    logic           cfg_valid_o;
    logic           cfg_drop_o;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_x_i;
    logic [N-1:0]   req_ready_o;
    logic           unit_start_o;
    logic [W-1:0]   unit_x_o;
    logic [W-1:0]   unit_m_o;
    logic [7:0]     unit_k_o;
    logic           unit_valid_i;
    logic [W-1:0]   unit_result_i;
    logic           rsp_valid_o;
    logic           rsp_ready_i;
    logic [1:0]     rsp_id_o;
    logic [W-1:0]   rsp_data_o;
    logic           rsp_err_o;
    logic           busy_o;
    logic [15:0]    done_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;

    bit           model_en = 1'b0;
    int           model_lat = 10;
    bit           model_fixed_en = 1'b0;
    logic [W-1:0] model_fixed = '0;
    bit           model_extra = 1'b0;

    cfg_vec_t cv [9];

    always #5 clk = ~clk;

    mont_reduce_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_m_i      (cfg_m_i),
        .cfg_valid_o  (cfg_valid_o),
        .cfg_drop_o   (cfg_drop_o),
        .req_valid_i  (req_valid_i),
        .req_x_i      (req_x_i),
        .req_ready_o  (req_ready_o),
        .unit_start_o (unit_start_o),
        .unit_x_o     (unit_x_o),
        .unit_m_o     (unit_m_o),
        .unit_k_o     (unit_k_o),
        .unit_valid_i (unit_valid_i),
        .unit_result_i(unit_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .done_cnt_o   (done_cnt_o)
    );

    // Unit model: completes model_lat cycles after the start cycle; result is x+1 unless fixed.
    // With model_extra it fires a stray completion two cycles later that must be ignored.
    initial begin
        logic [W-1:0] x_cap;
        unit_valid_i  = 1'b0;
        unit_result_i = '0;
        forever begin
            @(negedge clk);
            if (unit_start_o && model_en) begin
                x_cap = unit_x_o;
                repeat (model_lat) @(negedge clk);
                unit_valid_i  = 1'b1;
                unit_result_i = model_fixed_en ? model_fixed : (x_cap + 64'd1);
                @(negedge clk);
                unit_valid_i  = 1'b0;
                unit_result_i = '0;
                if (model_extra) begin
                    @(negedge clk);
                    unit_valid_i  = 1'b1;
                    unit_result_i = 64'hDEAD_BEEF;
                    @(negedge clk);
                    unit_valid_i  = 1'b0;
                    unit_result_i = '0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_x(input int r, input logic [W-1:0] v);
        req_x_i[r*W +: W] = v;
    endtask

    // Waits for the expected grant, follows it to the response, then holds rsp_ready low
    // for `hold` cycles before completing the handshake. Latency counts from the accept cycle.
    task automatic do_txn(input int exp_id, input logic [W-1:0] exp_x, input logic [W-1:0] exp_data,
                          input logic exp_err, input int exp_lat, input int hold,
                          input bit drop_req, input bit cfg_mid);
        int           n;
        int           starts;
        bit           got;
        logic [N-1:0] exp_rdy;
        exp_rdy = N'(1) << exp_id;
        #1;
        n = 0;
        while ((req_ready_o == '0) && (n < 20)) begin
            tick();
            n++;
        end
        chk("grant", 64'(req_ready_o), 64'(exp_rdy));
        tick();
        if (drop_req) req_valid_i = '0;
        n = 1;
        starts = 0;
        got = 1'b0;
        while (!got && (n < 400)) begin
            if (unit_start_o) begin
                starts++;
                chk("issue_x", unit_x_o, exp_x);
                chk("issue_m", unit_m_o, 64'h11);
                chk("issue_k", 64'(unit_k_o), 64'd5);
            end
            if (cfg_mid && (n == 2)) begin
                cfg_we_i = 1'b1;
                cfg_m_i  = 64'h13;
            end
            if (cfg_mid && (n == 3)) begin
                chk("busy_cfg_drop", 64'(cfg_drop_o), 64'd1);
                chk("busy_cfg_m", unit_m_o, 64'h11);
                chk("busy_cfg_k", 64'(unit_k_o), 64'd5);
                chk("busy_cfg_valid", 64'(cfg_valid_o), 64'd1);
                cfg_we_i = 1'b0;
                cfg_m_i  = '0;
            end
            if (rsp_valid_o) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'(exp_lat));
        chk("start_pulses", 64'(starts), 64'd1);
        chk("rsp_id", 64'(rsp_id_o), 64'(exp_id));
        chk("rsp_data", rsp_data_o, exp_data);
        chk("rsp_err", 64'(rsp_err_o), 64'(exp_err));
        chk("x_stable", unit_x_o, exp_x);
        $display("txn id=%0d data=%h err=%0d latency=%0d hold=%0d", rsp_id_o, rsp_data_o, rsp_err_o, n, hold);
        repeat (hold) begin
            tick();
            chk("hold_valid", 64'(rsp_valid_o), 64'd1);
            chk("hold_data", rsp_data_o, exp_data);
            chk("hold_id", 64'(rsp_id_o), 64'(exp_id));
            chk("hold_ready", 64'(req_ready_o), 64'd0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        exp_done++;
        chk("post_valid", 64'(rsp_valid_o), 64'd0);
        chk("post_data", rsp_data_o, 64'd0);
        chk("post_err", 64'(rsp_err_o), 64'd0);
        chk("done_cnt", 64'(done_cnt_o), 64'(exp_done));
    endtask

    initial begin
        cv[0] = '{64'h10,                  1'b1, 1'b0, 8'd0,  64'h0};
        cv[1] = '{64'h0,                   1'b1, 1'b0, 8'd0,  64'h0};
        cv[2] = '{64'h1,                   1'b1, 1'b0, 8'd0,  64'h0};
        cv[3] = '{64'h11,                  1'b0, 1'b1, 8'd5,  64'h11};
        cv[4] = '{64'h2,                   1'b1, 1'b1, 8'd5,  64'h11};
        cv[5] = '{64'h8000_0000_0000_0001, 1'b0, 1'b1, 8'd64, 64'h8000_0000_0000_0001};
        cv[6] = '{64'hFF,                  1'b0, 1'b1, 8'd8,  64'hFF};
        cv[7] = '{64'h3,                   1'b0, 1'b1, 8'd2,  64'h3};
        cv[8] = '{64'h11,                  1'b0, 1'b1, 8'd5,  64'h11};

        rst_i       = 1'b1;
        cfg_we_i    = 1'b0;
        cfg_m_i     = '0;
        req_valid_i = '0;
        req_x_i     = '0;
        rsp_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_valid", 64'(cfg_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_cnt_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_start", 64'(unit_start_o), 64'd0);
        chk("rst_k", 64'(unit_k_o), 64'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            cfg_we_i = 1'b1;
            cfg_m_i  = cv[i].m;
            tick();
            cfg_we_i = 1'b0;
            cfg_m_i  = '0;
            chk($sformatf("cfg%0d_drop", i), 64'(cfg_drop_o), 64'(cv[i].exp_drop));
            chk($sformatf("cfg%0d_valid", i), 64'(cfg_valid_o), 64'(cv[i].exp_valid));
            chk($sformatf("cfg%0d_k", i), 64'(unit_k_o), 64'(cv[i].exp_k));
            chk($sformatf("cfg%0d_m", i), unit_m_o, cv[i].exp_m);
            $display("cfg m=%h drop=%0d valid=%0d k=%0d", cv[i].m, cfg_drop_o, cfg_valid_o, unit_k_o);
            tick();
            chk($sformatf("cfg%0d_drop_end", i), 64'(cfg_drop_o), 64'd0);
        end

        // Config write and request in the same IDLE cycle: config wins, grant follows.
        req_valid_i = 4'b0010;
        cfg_we_i    = 1'b1;
        cfg_m_i     = 64'h11;
        #1;
        chk("prio_ready", 64'(req_ready_o), 64'd0);
        tick();
        cfg_we_i = 1'b0;
        cfg_m_i  = '0;
        #1;
        chk("prio_busy", 64'(busy_o), 64'd0);
        chk("prio_ready_after", 64'(req_ready_o), 64'b0010);
        req_valid_i = '0;
        tick();

        for (int r = 0; r < N; r++) set_x(r, 64'h100 + 64'(r));
        model_en       = 1'b1;
        model_lat      = 10;
        model_fixed_en = 1'b0;
        model_extra    = 1'b0;
        req_valid_i    = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            do_txn(t % 4, 64'h100 + 64'(t % 4), 64'h101 + 64'(t % 4), 1'b0, 12, 0, t == 4, 1'b0);
        end

        set_x(0, 64'h2A);
        model_fixed_en = 1'b1;
        model_fixed    = 64'h7;
        req_valid_i    = 4'b0001;
        do_txn(0, 64'h2A, 64'h7, 1'b0, 12, 0, 1'b1, 1'b1);
        model_fixed_en = 1'b0;

        set_x(2, 64'h222);
        model_lat   = 2;
        req_valid_i = 4'b0101;
        do_txn(2, 64'h222, 64'h223, 1'b0, 4, 0, 1'b0, 1'b0);
        do_txn(0, 64'h2A, 64'h2B, 1'b0, 4, 0, 1'b1, 1'b0);

        set_x(3, 64'h333);
        model_lat   = 3;
        model_extra = 1'b1;
        req_valid_i = 4'b1000;
        do_txn(3, 64'h333, 64'h334, 1'b0, 5, 5, 1'b0, 1'b0);
        req_valid_i = '0;
        model_extra = 1'b0;
        tick();

        set_x(1, 64'h111);
        model_en    = 1'b0;
        req_valid_i = 4'b0010;
        do_txn(1, 64'h111, 64'h0, 1'b1, TO + 2, 0, 1'b1, 1'b0);

        model_en    = 1'b1;
        model_lat   = TO;
        req_valid_i = 4'b0010;
        do_txn(1, 64'h111, 64'h112, 1'b0, TO + 2, 0, 1'b1, 1'b0);

        // Reset while WAIT is in flight: everything drops at once, no response afterwards.
        model_en    = 1'b0;
        req_valid_i = 4'b0100;
        #1;
        chk("rst_seq_grant", 64'(req_ready_o), 64'b0100);
        tick();
        req_valid_i = '0;
        repeat (6) tick();
        chk("rst_seq_busy", 64'(busy_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_cfg_valid", 64'(cfg_valid_o), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("arst_rsp_id", 64'(rsp_id_o), 64'd0);
        chk("arst_rsp_err", 64'(rsp_err_o), 64'd0);
        chk("arst_start", 64'(unit_start_o), 64'd0);
        chk("arst_x", unit_x_o, 64'd0);
        chk("arst_m", unit_m_o, 64'd0);
        chk("arst_k", 64'(unit_k_o), 64'd0);
        chk("arst_done", 64'(done_cnt_o), 64'd0);
        tick();
        rst_i    = 1'b0;
        exp_done = 0;
        req_valid_i = 4'b1111;
        repeat (3) begin
            tick();
            chk("post_rst_ready", 64'(req_ready_o), 64'd0);
            chk("post_rst_rsp", 64'(rsp_valid_o), 64'd0);
            chk("post_rst_busy", 64'(busy_o), 64'd0);
        end
        cfg_we_i = 1'b1;
        cfg_m_i  = 64'h11;
        tick();
        cfg_we_i = 1'b0;
        cfg_m_i  = '0;
        #1;
        chk("post_rst_cfg_valid", 64'(cfg_valid_o), 64'd1);
        chk("post_rst_ptr0", 64'(req_ready_o), 64'b0001);
        req_valid_i = '0;
        #1;
        chk("post_rst_idle", 64'(busy_o), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
